// File: rtl/status_flush_pkg.sv
// Shared types and helpers for the status capture / flush path.
package status_flush_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } flush_state_e;

    // Default flag positions for the 5-bit control-path status word.
    localparam int IMG1  = 0;
    localparam int IMG2  = 1;
    localparam int ERASE = 2;
    localparam int ERR   = 3;
    localparam int BOOT  = 4;

    // Number of bytes needed to carry a status word of the given width.
    function automatic int num_bytes(input int width);
        return (width + 7) / 8;
    endfunction

endpackage

// File: rtl/status_live_reg.sv
// Live status register: the first accumulates, the second is sticky.
// Live bits follow the input. Sticky bits OR-accumulate and are cleared
// when a snapshot is taken. merged_o is the next-state value before that
// clear, so a snapshot taken in the same cycle as an update includes it.
module status_live_reg
    import status_flush_pkg::*;
#(
    parameter int                    STAT_WIDTH  = 5,
    parameter logic [STAT_WIDTH-1:0] STICKY_MASK = STAT_WIDTH'(5'b01000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAT_WIDTH-1:0] status_i,
    input  logic                  valid_i,
    input  logic                  clear_i,
    output logic [STAT_WIDTH-1:0] merged_o
);

    logic [STAT_WIDTH-1:0] live_q;
    logic [STAT_WIDTH-1:0] live_d;

    // Merge the qualified input into the held flags.
    always_comb begin
        merged_o = live_q;
        if (valid_i) begin
            merged_o = (status_i & ~STICKY_MASK) | ((live_q | status_i) & STICKY_MASK);
        end
        live_d = clear_i ? (merged_o & ~STICKY_MASK) : merged_o;
    end

    // Hold the live flags; sticky events are reported exactly once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= '0;
        end else begin
            live_q <= live_d;
        end
    end

endmodule

// File: rtl/status_flush_ctrl.sv
// Status capture and flush: snapshots the live flags on request and
// streams the snapshot LSB-first as bytes over valid/ready.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | no transfer; start_flush takes a snapshot
//   SEND  | presenting snap byte idx; one request may queue in pend
module status_flush_ctrl
    import status_flush_pkg::*;
#(
    parameter int                    STAT_WIDTH  = 5,
    parameter logic [STAT_WIDTH-1:0] STICKY_MASK = STAT_WIDTH'(5'b01000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [STAT_WIDTH-1:0] in_status_flush,
    input  logic                  in_valid_flush,
    input  logic                  start_flush,
    input  logic                  out_ready_flush,
    output logic [7:0]            out_data_flush,
    output logic                  out_valid_flush,
    output logic                  out_last_flush,
    output logic                  busy_flush,
    output logic                  missed_flush
);

    localparam int NUM_BYTES = num_bytes(STAT_WIDTH);
    localparam int IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam int PAD_W     = NUM_BYTES * 8;

    flush_state_e          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  pend_q, pend_d;
    logic                  missed_q, missed_d;
    logic [PAD_W-1:0]      snap_q, snap_d;
    logic                  snap_en;
    logic                  at_last;
    logic [STAT_WIDTH-1:0] live_merged;

    status_live_reg #(
        .STAT_WIDTH  (STAT_WIDTH),
        .STICKY_MASK (STICKY_MASK)
    ) u_live (
        .clk      (clk),
        .rst      (rst),
        .status_i (in_status_flush),
        .valid_i  (in_valid_flush),
        .clear_i  (snap_en),
        .merged_o (live_merged)
    );

    assign at_last = (idx_q == IDX_W'(NUM_BYTES - 1));

    // Next-state: a request on the final accepted byte is treated as
    // arriving with pend clear, so it can chain without an idle cycle.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        pend_d   = pend_q;
        missed_d = missed_q;
        snap_en  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_flush) begin
                    snap_en = 1'b1;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (out_ready_flush && at_last) begin
                    if (pend_q || start_flush) begin
                        snap_en = 1'b1;
                        idx_d   = '0;
                        pend_d  = pend_q && start_flush;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (out_ready_flush) begin
                        idx_d = idx_q + 1'b1;
                    end
                    if (start_flush) begin
                        if (pend_q) begin
                            missed_d = 1'b1;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        snap_d = snap_en ? PAD_W'(live_merged) : snap_q;
    end

    // Control state, byte index, queued request and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            pend_q   <= 1'b0;
            missed_q <= 1'b0;
            snap_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            pend_q   <= pend_d;
            missed_q <= missed_d;
            snap_q   <= snap_d;
        end
    end

    // Byte select from registered snapshot and index only.
    always_comb begin
        out_data_flush = 8'h00;
        for (int b = 0; b < NUM_BYTES; b++) begin
            if (idx_q == IDX_W'(b)) begin
                out_data_flush = snap_q[8*b +: 8];
            end
        end
    end

    assign out_valid_flush = (state_q == SEND);
    assign out_last_flush  = (state_q == SEND) && at_last;
    assign busy_flush      = (state_q != IDLE) || pend_q;
    assign missed_flush    = missed_q;

endmodule

// File: tb/tb_status_flush_ctrl.sv
module tb_status_flush_ctrl;
    import status_flush_pkg::*;

    logic clk;
    logic rst;

    logic [4:0]  st5;
    logic        v5, s5, r5;
    logic [7:0]  od5;
    logic        ov5, ol5, ob5, om5;

    logic [11:0] st12;
    logic        v12, s12, r12;
    logic [7:0]  od12;
    logic        ov12, ol12, ob12, om12;

    int n_cmp;
    int n_err;

    status_flush_ctrl u_d5 (
        .clk             (clk),
        .rst             (rst),
        .in_status_flush (st5),
        .in_valid_flush  (v5),
        .start_flush     (s5),
        .out_ready_flush (r5),
        .out_data_flush  (od5),
        .out_valid_flush (ov5),
        .out_last_flush  (ol5),
        .busy_flush      (ob5),
        .missed_flush    (om5)
    );

    status_flush_ctrl #(
        .STAT_WIDTH  (12),
        .STICKY_MASK (12'h008)
    ) u_d12 (
        .clk             (clk),
        .rst             (rst),
        .in_status_flush (st12),
        .in_valid_flush  (v12),
        .start_flush     (s12),
        .out_ready_flush (r12),
        .out_data_flush  (od12),
        .out_valid_flush (ov12),
        .out_last_flush  (ol12),
        .busy_flush      (ob12),
        .missed_flush    (om12)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] st;
        logic       v;
        logic       s;
        logic       r;
        logic       ev;
        logic [7:0] ed;
        logic       el;
        logic       eb;
        logic       em;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk12(input string nm, input logic ev, input logic [7:0] ed,
                         input logic el, input logic eb, input logic em);
        check({nm, ".valid"}, 16'(ov12), 16'(ev));
        if (ev) check({nm, ".data"}, 16'(od12), 16'(ed));
        check({nm, ".last"}, 16'(ol12), 16'(el));
        check({nm, ".busy"}, 16'(ob12), 16'(eb));
        check({nm, ".missed"}, 16'(om12), 16'(em));
    endtask

    task automatic drv12(input logic [11:0] st, input logic v, input logic s, input logic r);
        st12 = st;
        v12  = v;
        s12  = s;
        r12  = r;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        st5 = '0; v5 = 1'b0; s5 = 1'b0; r5 = 1'b0;
        drv12(12'h000, 1'b0, 1'b0, 1'b0);

        //            st        v     s     r     ev    ed     el    eb    em
        vecs[0]  = '{5'b10011, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{5'b00000, 1'b0, 1'b1, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1, 1'b0};
        vecs[2]  = '{5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{5'b01000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{5'b00000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h08, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{5'b00000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{5'b01001, 1'b1, 1'b1, 1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{5'b00000, 1'b0, 1'b0, 1'b0, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{5'b00110, 1'b1, 1'b1, 1'b1, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{5'b00000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{5'b10000, 1'b1, 1'b1, 1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 1'b1};
        vecs[18] = '{5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 1'b1, 1'b1, 1'b1};
        vecs[19] = '{5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        #12;
        check("rst5.valid", 16'(ov5), 16'h0);
        check("rst5.data", 16'(od5), 16'h0);
        check("rst5.busy", 16'(ob5), 16'h0);
        check("rst5.missed", 16'(om5), 16'h0);
        check("rst12.valid", 16'(ov12), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Default-width table: capture, sticky, same-cycle set, back-to-back, pend/missed.
        for (int i = 0; i < 20; i++) begin
            st5 = vecs[i].st;
            v5  = vecs[i].v;
            s5  = vecs[i].s;
            r5  = vecs[i].r;
            step();
            check($sformatf("v%0d.valid", i), 16'(ov5), 16'(vecs[i].ev));
            if (vecs[i].ev) check($sformatf("v%0d.data", i), 16'(od5), 16'(vecs[i].ed));
            check($sformatf("v%0d.last", i), 16'(ol5), 16'(vecs[i].el));
            check($sformatf("v%0d.busy", i), 16'(ob5), 16'(vecs[i].eb));
            check($sformatf("v%0d.missed", i), 16'(om5), 16'(vecs[i].em));
        end
        s5 = 1'b0; v5 = 1'b0; r5 = 1'b0;

        // 12-bit word, ready toggling with a stall on the last byte.
        drv12(12'hABC, 1'b1, 1'b0, 1'b0); step(); chk12("a0", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drv12(12'h000, 1'b0, 1'b1, 1'b0); step(); chk12("a1", 1'b1, 8'hBC, 1'b0, 1'b1, 1'b0);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("a2", 1'b1, 8'h0A, 1'b1, 1'b1, 1'b0);
        drv12(12'h000, 1'b0, 1'b0, 1'b0); step(); chk12("a3", 1'b1, 8'h0A, 1'b1, 1'b1, 1'b0);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("a4", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Requests under backpressure: one queues, the rest are dropped.
        drv12(12'h123, 1'b1, 1'b1, 1'b0); step(); chk12("b1", 1'b1, 8'h23, 1'b0, 1'b1, 1'b0);
        drv12(12'h456, 1'b1, 1'b1, 1'b0); step(); chk12("b2", 1'b1, 8'h23, 1'b0, 1'b1, 1'b0);
        drv12(12'h000, 1'b0, 1'b1, 1'b0); step(); chk12("b3", 1'b1, 8'h23, 1'b0, 1'b1, 1'b1);
        drv12(12'h000, 1'b0, 1'b1, 1'b0); step(); chk12("b4", 1'b1, 8'h23, 1'b0, 1'b1, 1'b1);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("b5", 1'b1, 8'h01, 1'b1, 1'b1, 1'b1);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("b6", 1'b1, 8'h56, 1'b0, 1'b1, 1'b1);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("b7", 1'b1, 8'h04, 1'b1, 1'b1, 1'b1);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("b8", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Reset while byte 0 of 2 is held.
        drv12(12'h7E5, 1'b1, 1'b1, 1'b0); step(); chk12("c1", 1'b1, 8'hE5, 1'b0, 1'b1, 1'b1);
        drv12(12'h000, 1'b0, 1'b0, 1'b0); step(); chk12("c2", 1'b1, 8'hE5, 1'b0, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("c.async_valid", 16'(ov12), 16'h0);
        check("c.async_busy", 16'(ob12), 16'h0);
        check("c.async_missed", 16'(om12), 16'h0);
        check("c.async_missed5", 16'(om5), 16'h0);
        step();
        check("c.hold_valid", 16'(ov12), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        r12 = 1'b1;
        step(); chk12("c3", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drv12(12'h321, 1'b1, 1'b1, 1'b0); step(); chk12("c4", 1'b1, 8'h21, 1'b0, 1'b1, 1'b0);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("c5", 1'b1, 8'h03, 1'b1, 1'b1, 1'b0);
        drv12(12'h000, 1'b0, 1'b0, 1'b1); step(); chk12("c6", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
